dmem_lsu: RTL and testbench
===========================

DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, data RAM depth in 32-bit words (power of two).
REQ-002 Parameter AW, default $clog2(DEPTH_WORDS), word-index width.
REQ-003 clk  in  1  single clock, all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 mem_en  in  1  access strobe from the control FSM.
REQ-006 mem_wen  in  1  1=write, 0=read; qualified by mem_en.
REQ-007 mem_size  in  2  00 byte, 01 half, 10 word; 11 treated as word.
REQ-008 mem_unsigned  in  1  load zero-extend (1) or sign-extend (0).
REQ-009 addr  in  32  byte address (ALUOut).
REQ-010 wdata  in  32  store source (B register); byte/half taken from low bits.
REQ-011 ld_mdr  in  1  capture RAM read word into MDR.
REQ-012 load_data  out  32  extracted, extended load value (writeback mux input 1).
REQ-013 rd_valid  out  1  RAM read word valid this cycle.
REQ-014 misalign_err  out  1  sticky misaligned-access flag.
REQ-015 err_addr  out  32  address of first misaligned access since clear.
REQ-016 clr_err  in  1  clears misalign_err and err_addr.

Function
REQ-017 Word index = addr[AW+1:2]; higher address bits ignored (wrap); byte offset = addr[1:0]; little-endian, byte k at bits 8k+7:8k.
REQ-018 Aligned = byte any offset, half with addr[0]=0, word with addr[1:0]=00.
REQ-019 Aligned read (mem_en=1, mem_wen=0) in cycle T: RAM word valid at T+1 with rd_valid=1 for exactly that cycle; offset, size, unsigned latched at T into read-context registers.
REQ-020 ld_mdr=1 captures current RAM output word into MDR; without a preceding read it recaptures the last read word.
REQ-021 load_data combinational from MDR and read context: byte lane per offset, half lane per addr[1], word whole; extension per latched unsigned bit.
REQ-022 Aligned word write: RAM[index] <= wdata at the edge ending the mem_en cycle.
REQ-023 Aligned byte/half write (RMW): RAM[index] <= MDR with selected lane replaced by wdata[7:0] or wdata[15:0]; other lanes unchanged.
REQ-024 Misaligned access: RAM not written, no read issued, rd_valid stays 0, MDR unchanged, misalign_err set next cycle.
REQ-025 err_addr captured only when misalign_err is 0 (first error wins).
REQ-026 clr_err concurrent with new misaligned access: set wins, err_addr takes new address.
REQ-027 mem_wen with mem_en=0 has no effect.
REQ-028 RAM output register holds its value when no read issued.

Reset
REQ-029 rst_n low: MDR, RAM output register, read context, err_addr = 0; rd_valid, misalign_err = 0; load_data therefore 0.
REQ-030 RAM contents not reset; reset mid-read discards the pending read (rd_valid 0 after release).

Structure
REQ-031 mem_size encodings (MS_BYTE, MS_HALF, MS_WORD) live in the shared cpu package, used by both control and this block.
REQ-032 Storage is sub-module dmem_ram: single-port synchronous word RAM, one write-enable, registered read, DEPTH_WORDS deep.
REQ-033 Lane extract and merge logic stay in dmem_lsu.

Verification
REQ-034 Word write 0xDEADBEEF @0x10, read @0x10, ld_mdr -> load_data 0xDEADBEEF, rd_valid one cycle after read strobe.
REQ-035 RAM[0x10]=0xDEADBEEF, LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD; LHU @0x10 -> 0x0000BEEF.
REQ-036 RMW SB wdata=0x55 @0x11 over 0xDEADBEEF (read, ld_mdr, write) -> RAM word 0xDEAD55EF; SH 0x1234 @0x12 -> 0x123455EF.
REQ-037 Word write @0x22 -> no RAM change, misalign_err=1, err_addr=0x22; second misaligned @0x31 -> err_addr stays 0x22; clr_err -> both 0.
REQ-038 rst_n asserted between read strobe and next cycle -> rd_valid 0, MDR 0, load_data 0; RAM contents preserved.
REQ-039 Address 0x10 + 4*DEPTH_WORDS -> aliases word 4 (wrap).

Source files
------------

// File: rtl/dmem_lsu_pkg.sv
// Shared load/store definitions: access-size encodings,
// read-context bundle and the alignment rule.
package dmem_lsu_pkg;

   localparam logic [1:0] MS_BYTE = 2'b00;
   localparam logic [1:0] MS_HALF = 2'b01;
   localparam logic [1:0] MS_WORD = 2'b10;

   typedef struct packed {
      logic [1:0] off;
      logic [1:0] size;
      logic       uns;
   } rd_ctx_t;

   // Size 2'b11 is handled as a word.
   function automatic logic is_aligned(input logic [1:0] size,
                                       input logic [1:0] off);
      logic ok;
      ok = 1'b0;
      unique case (1'b1)
         (size == MS_BYTE): ok = 1'b1;
         (size == MS_HALF): ok = ~off[0];
         default:           ok = (off == 2'b00);
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Control <-> load/store unit bus.
// master: control FSM side, slave: dmem_lsu side.
interface dmem_lsu_if;
   logic        mem_en;
   logic        mem_wen;
   logic [1:0]  mem_size;
   logic        mem_unsigned;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        ld_mdr;
   logic        clr_err;
   logic [31:0] load_data;
   logic        rd_valid;
   logic        misalign_err;
   logic [31:0] err_addr;

   modport master (
      output mem_en, mem_wen, mem_size, mem_unsigned,
      output addr, wdata, ld_mdr, clr_err,
      input  load_data, rd_valid, misalign_err, err_addr
   );

   modport slave (
      input  mem_en, mem_wen, mem_size, mem_unsigned,
      input  addr, wdata, ld_mdr, clr_err,
      output load_data, rd_valid, misalign_err, err_addr
   );
endinterface

// File: rtl/dmem_ram.sv
// Single-port synchronous word RAM, registered read.
// Ports: clk, rst_n, we, re, idx, wdata -> rdata.
module dmem_ram #(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic          re,
   input  logic [AW-1:0] idx,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   // Array contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (we) mem[idx] <= wdata;
   end

   // Output register holds its value between reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  rdata <= '0;
      else if (re) rdata <= mem[idx];
   end

endmodule

// File: rtl/dmem_lsu.sv
// Data-memory load/store unit: alignment check, RMW merge,
// MDR, load extract/extend, sticky misalign error.
// Ports: clk, rst_n, bus (dmem_lsu_if.slave).
module dmem_lsu
   import dmem_lsu_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW = $clog2(DEPTH_WORDS)
) (
   input  logic       clk,
   input  logic       rst_n,
   dmem_lsu_if.slave  bus
);

   logic [AW-1:0] idx;
   logic [1:0]    off;
   logic          aligned;
   logic          acc_ok;
   logic          acc_bad;
   logic          ram_we;
   logic          ram_re;
   logic [31:0]   ram_rdata;
   logic [31:0]   wr_word;
   logic [31:0]   mdr;
   rd_ctx_t       ctx;
   logic          rd_valid_q;
   logic          err_q;
   logic [31:0]   err_addr_q;
   logic          unused_hi;

   // Upper address bits wrap.
   assign idx       = bus.addr[AW+1:2];
   assign off       = bus.addr[1:0];
   assign unused_hi = ^bus.addr[31:AW+2];

   assign aligned = is_aligned(bus.mem_size, off);
   assign acc_ok  = bus.mem_en & aligned;
   assign acc_bad = bus.mem_en & ~aligned;
   assign ram_we  = acc_ok & bus.mem_wen;
   assign ram_re  = acc_ok & ~bus.mem_wen;

   // Sub-word stores replace one lane of the MDR word,
   // which the control FSM loads beforehand.
   always_comb begin
      wr_word = bus.wdata;
      unique case (1'b1)
         (bus.mem_size == MS_BYTE): begin
            wr_word = mdr;
            wr_word[{off, 3'b000} +: 8] = bus.wdata[7:0];
         end
         (bus.mem_size == MS_HALF): begin
            wr_word = mdr;
            wr_word[{off[1], 4'b0000} +: 16] = bus.wdata[15:0];
         end
         default: wr_word = bus.wdata;
      endcase
   end

   dmem_ram #(
      .DEPTH_WORDS(DEPTH_WORDS),
      .AW(AW)
   ) u_ram (
      .clk(clk),
      .rst_n(rst_n),
      .we(ram_we),
      .re(ram_re),
      .idx(idx),
      .wdata(wr_word),
      .rdata(ram_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid_q <= 1'b0;
         ctx        <= '0;
         mdr        <= '0;
      end else begin
         rd_valid_q <= ram_re;
         if (ram_re) ctx <= '{off: off, size: bus.mem_size, uns: bus.mem_unsigned};
         if (bus.ld_mdr) mdr <= ram_rdata;
      end
   end

   // First error address wins; a new fault beats clr_err.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q      <= 1'b0;
         err_addr_q <= '0;
      end else if (acc_bad) begin
         err_q <= 1'b1;
         if (!err_q || bus.clr_err) err_addr_q <= bus.addr;
      end else if (bus.clr_err) begin
         err_q      <= 1'b0;
         err_addr_q <= '0;
      end
   end

   always_comb begin
      logic [7:0]  b;
      logic [15:0] h;
      b = mdr[{ctx.off, 3'b000} +: 8];
      h = ctx.off[1] ? mdr[31:16] : mdr[15:0];
      bus.load_data = mdr;
      unique case (1'b1)
         (ctx.size == MS_BYTE):
            bus.load_data = {{24{~ctx.uns & b[7]}}, b};
         (ctx.size == MS_HALF):
            bus.load_data = {{16{~ctx.uns & h[15]}}, h};
         default: bus.load_data = mdr;
      endcase
   end

   assign bus.rd_valid     = rd_valid_q;
   assign bus.misalign_err = err_q;
   assign bus.err_addr     = err_addr_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed self-checking bench for dmem_lsu:
// load vector table plus RMW, error, reset and wrap sequences.
module tb_dmem_lsu;
   import dmem_lsu_pkg::*;

   localparam int DEPTH = 1024;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   dmem_lsu_if bus ();

   dmem_lsu #(
      .DEPTH_WORDS(DEPTH)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %08h want %08h", name, act, exp);
      end
   endtask

   task automatic idle();
      bus.mem_en       = 1'b0;
      bus.mem_wen      = 1'b0;
      bus.mem_size     = MS_WORD;
      bus.mem_unsigned = 1'b0;
      bus.addr         = '0;
      bus.wdata        = '0;
      bus.ld_mdr       = 1'b0;
      bus.clr_err      = 1'b0;
   endtask

   // All tasks start and end on a falling edge.
   task automatic wr(input logic [31:0] a, input logic [1:0] s,
                     input logic [31:0] d);
      bus.mem_en   = 1'b1;
      bus.mem_wen  = 1'b1;
      bus.mem_size = s;
      bus.addr     = a;
      bus.wdata    = d;
      @(negedge clk);
      bus.mem_en  = 1'b0;
      bus.mem_wen = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, input logic [1:0] s,
                     input logic u);
      bus.mem_en       = 1'b1;
      bus.mem_wen      = 1'b0;
      bus.mem_size     = s;
      bus.mem_unsigned = u;
      bus.addr         = a;
      @(negedge clk);
      bus.mem_en = 1'b0;
      chk("rd_valid_t1", {31'b0, bus.rd_valid}, 32'd1);
      bus.ld_mdr = 1'b1;
      @(negedge clk);
      bus.ld_mdr = 1'b0;
      chk("rd_valid_t2", {31'b0, bus.rd_valid}, 32'd0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      vecs[0] = '{MS_BYTE, 1'b0, 32'h13, 32'hFFFF_FFDE};
      vecs[1] = '{MS_BYTE, 1'b1, 32'h13, 32'h0000_00DE};
      vecs[2] = '{MS_HALF, 1'b0, 32'h12, 32'hFFFF_DEAD};
      vecs[3] = '{MS_HALF, 1'b1, 32'h10, 32'h0000_BEEF};
      vecs[4] = '{MS_BYTE, 1'b0, 32'h10, 32'hFFFF_FFEF};
      vecs[5] = '{MS_BYTE, 1'b1, 32'h11, 32'h0000_00BE};
      vecs[6] = '{MS_HALF, 1'b0, 32'h10, 32'hFFFF_BEEF};
      vecs[7] = '{MS_WORD, 1'b0, 32'h10, 32'hDEAD_BEEF};
      vecs[8] = '{2'b11,   1'b1, 32'h10, 32'hDEAD_BEEF};
      vecs[9] = '{MS_BYTE, 1'b0, 32'h12, 32'hFFFF_FFAD};

      idle();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_load_data", bus.load_data, 32'h0);
      chk("rst_rd_valid", {31'b0, bus.rd_valid}, 32'd0);
      chk("rst_err", {31'b0, bus.misalign_err}, 32'd0);
      chk("rst_err_addr", bus.err_addr, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // Word write then word read.
      wr(32'h10, MS_WORD, 32'hDEAD_BEEF);
      rd(32'h10, MS_WORD, 1'b0);
      chk("lw_10", bus.load_data, 32'hDEAD_BEEF);

      for (int i = 0; i < 10; i++) begin
         rd(vecs[i].addr, vecs[i].size, vecs[i].uns);
         chk($sformatf("load_vec%0d", i), bus.load_data, vecs[i].exp);
      end

      // Byte / half RMW.
      rd(32'h10, MS_WORD, 1'b0);
      wr(32'h11, MS_BYTE, 32'hFFFF_FF55);
      rd(32'h10, MS_WORD, 1'b0);
      chk("sb_rmw", bus.load_data, 32'hDEAD_55EF);
      wr(32'h12, MS_HALF, 32'hABCD_1234);
      rd(32'h10, MS_WORD, 1'b0);
      chk("sh_rmw", bus.load_data, 32'h1234_55EF);

      // Write with mem_en low is ignored.
      wr(32'h20, MS_WORD, 32'h1122_3344);
      bus.mem_wen = 1'b1;
      bus.addr    = 32'h20;
      bus.wdata   = 32'h0;
      @(negedge clk);
      bus.mem_wen = 1'b0;
      rd(32'h20, MS_WORD, 1'b0);
      chk("wen_no_en", bus.load_data, 32'h1122_3344);

      // Misaligned word write.
      wr(32'h22, MS_WORD, 32'hFFFF_FFFF);
      chk("mis_err", {31'b0, bus.misalign_err}, 32'd1);
      chk("mis_addr", bus.err_addr, 32'h22);
      chk("mis_no_rdv", {31'b0, bus.rd_valid}, 32'd0);
      rd(32'h20, MS_WORD, 1'b0);
      chk("mis_no_write", bus.load_data, 32'h1122_3344);

      // Misaligned read: no read issued, first address kept.
      bus.mem_en   = 1'b1;
      bus.mem_size = MS_HALF;
      bus.addr     = 32'h31;
      @(negedge clk);
      bus.mem_en = 1'b0;
      chk("mis2_no_rdv", {31'b0, bus.rd_valid}, 32'd0);
      chk("mis2_addr", bus.err_addr, 32'h22);
      chk("mis2_err", {31'b0, bus.misalign_err}, 32'd1);
      bus.ld_mdr = 1'b1;
      @(negedge clk);
      bus.ld_mdr = 1'b0;
      chk("mdr_recapture", bus.load_data, 32'h1122_3344);

      bus.clr_err = 1'b1;
      @(negedge clk);
      bus.clr_err = 1'b0;
      chk("clr_err", {31'b0, bus.misalign_err}, 32'd0);
      chk("clr_addr", bus.err_addr, 32'h0);

      // New fault concurrent with clear: set wins.
      wr(32'h41, MS_HALF, 32'h0);
      chk("e41_addr", bus.err_addr, 32'h41);
      bus.clr_err = 1'b1;
      wr(32'h43, MS_WORD, 32'h0);
      bus.clr_err = 1'b0;
      chk("setwin_err", {31'b0, bus.misalign_err}, 32'd1);
      chk("setwin_addr", bus.err_addr, 32'h43);
      bus.clr_err = 1'b1;
      @(negedge clk);
      bus.clr_err = 1'b0;
      chk("clr2_err", {31'b0, bus.misalign_err}, 32'd0);

      // Reset between read strobe and data cycle.
      bus.mem_en   = 1'b1;
      bus.mem_wen  = 1'b0;
      bus.mem_size = MS_WORD;
      bus.addr     = 32'h10;
      @(posedge clk);
      #1 rst_n = 1'b0;
      bus.mem_en = 1'b0;
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("rstmid_rdv", {31'b0, bus.rd_valid}, 32'd0);
      chk("rstmid_ld", bus.load_data, 32'h0);
      bus.ld_mdr = 1'b1;
      @(negedge clk);
      bus.ld_mdr = 1'b0;
      chk("rstmid_mdr", bus.load_data, 32'h0);
      rd(32'h10, MS_WORD, 1'b0);
      chk("rstmid_ram", bus.load_data, 32'h1234_55EF);

      // Address wrap aliases word 4.
      wr(32'h10 + 32'(4 * DEPTH), MS_WORD, 32'hCAFE_F00D);
      rd(32'h10, MS_WORD, 1'b0);
      chk("wrap", bus.load_data, 32'hCAFE_F00D);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
